encoder32_pending: RTL and testbench

//  Reverse direction of the 32-line decoder. Latches 32 request lines into
//    a sticky pending vector and priority-encodes the pending vector into
//    a registered 5-bit index.

---
 rtl/encoder32_pending_if.sv | 21 ++
 rtl/encoder32_pending.sv | 99 +++++++++
 tb/tb_encoder32_pending.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder32_pending_if.sv
// rtl/encoder32_pending_if.sv - request/mask inputs and grant handshake of encoder32_pending
// master: the request/consumer side; slave: the encoder itself.
interface encoder32_pending_if;
  logic        enable;
  logic [31:0] reqIn;
  logic [31:0] maskIn;
  logic        ackIn;
  logic        validOut;
  logic [4:0]  indexOut;
  logic [31:0] pendingOut;

  modport master (
    output enable, reqIn, maskIn, ackIn,
    input  validOut, indexOut, pendingOut
  );

  modport slave (
    input  enable, reqIn, maskIn, ackIn,
    output validOut, indexOut, pendingOut
  );
endinterface

// File: rtl/encoder32_pending.sv
// rtl/encoder32_pending.sv - sticky 32-source pending latch with registered priority encoder
// Define ENCODER32_ROUND_ROBIN_EN for rotating priority; fixed lowest-bit-first otherwise.
module encoder32_pending #(
  parameter int EDGE_DETECT = 0
) (
  input  logic               clk,
  input  logic               reset,
  encoder32_pending_if.slave bus
);

  typedef enum logic {IDLE, HOLD} stateType;

  stateType    state;
  logic [31:0] pending;
  logic [31:0] reqPrev;
  logic [31:0] setVec;
  logic [31:0] clrVec;
  logic [31:0] eligible;
  logic        validReg;
  logic [4:0]  indexReg;
  logic [4:0]  select;
`ifdef ENCODER32_ROUND_ROBIN_EN
  logic [4:0]  rrPtr;
  logic [4:0]  cand;
`endif

  always_comb begin
    if (!bus.enable) begin
      setVec = '0;
    end else if (EDGE_DETECT != 0) begin
      setVec = bus.reqIn & ~reqPrev;
    end else begin
      setVec = bus.reqIn;
    end
  end

  // Only the granted index is ever cleared, and only on its acknowledge.
  assign clrVec   = (state == HOLD && bus.ackIn) ? (32'd1 << indexReg) : '0;
  assign eligible = pending & ~bus.maskIn;

  // Scan from the far end toward the start point so the nearest hit is written last.
  always_comb begin
    select = '0;
`ifdef ENCODER32_ROUND_ROBIN_EN
    cand = '0;
    for (int i = 31; i >= 0; i--) begin
      cand = rrPtr + 5'(i);
      if (eligible[cand]) begin
        select = cand;
      end
    end
`else
    for (int i = 31; i >= 0; i--) begin
      if (eligible[i]) begin
        select = 5'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      reqPrev  <= '0;
      validReg <= 1'b0;
      indexReg <= '0;
      state    <= IDLE;
`ifdef ENCODER32_ROUND_ROBIN_EN
      rrPtr    <= '0;
`endif
    end else begin
      reqPrev <= bus.reqIn;
      pending <= (pending & ~clrVec) | setVec;
      case (state)
        IDLE: begin
          if (eligible != '0) begin
            indexReg <= select;
            validReg <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ackIn) begin
            validReg <= 1'b0;
            state    <= IDLE;
`ifdef ENCODER32_ROUND_ROBIN_EN
            rrPtr    <= indexReg + 5'd1;
`endif
          end
        end
      endcase
    end
  end

  assign bus.validOut   = validReg;
  assign bus.indexOut   = indexReg;
  assign bus.pendingOut = pending;

endmodule

// File: tb/tb_encoder32_pending.sv
// tb/tb_encoder32_pending.sv - randomized and directed check of encoder32_pending against a behavioural model
// Two instances: level capture (index 0) and edge capture (index 1).
module tb_encoder32_pending;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [31:0] req = '0;
  logic [31:0] mask = '0;
  logic        ackV [2];
  logic        started = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  encoder32_pending_if if0 ();
  encoder32_pending_if if1 ();

  assign if0.enable = en;
  assign if0.reqIn  = req;
  assign if0.maskIn = mask;
  assign if0.ackIn  = ackV[0];
  assign if1.enable = en;
  assign if1.reqIn  = req;
  assign if1.maskIn = mask;
  assign if1.ackIn  = ackV[1];

  encoder32_pending #(.EDGE_DETECT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  encoder32_pending #(.EDGE_DETECT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic        dVal [2];
  logic [4:0]  dIdx [2];
  logic [31:0] dPend [2];
  assign dVal[0] = if0.validOut;
  assign dIdx[0] = if0.indexOut;
  assign dPend[0] = if0.pendingOut;
  assign dVal[1] = if1.validOut;
  assign dIdx[1] = if1.indexOut;
  assign dPend[1] = if1.pendingOut;

  logic [31:0] mPend [2];
  logic [31:0] mPrev [2];
  logic        mValid [2];
  logic [4:0]  mIdx [2];
  logic [4:0]  mRr [2];

  // Rotate so the start point sits at bit 0, isolate the lowest set bit, rotate back.
  function automatic logic [4:0] pick(input logic [31:0] e, input logic [4:0] p);
    logic [63:0] dbl;
    logic [31:0] rot;
    logic [31:0] low;
    int k;
    dbl = {e, e} >> p;
    rot = dbl[31:0];
    low = rot & (~rot + 32'd1);
    k = $clog2(low);
    return 5'((k + int'(p)) % 32);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", name, k, got, want, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [31:0] setV, clrV, elig;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mPend[k] = '0; mPrev[k] = '0; mValid[k] = 1'b0; mIdx[k] = '0; mRr[k] = '0;
      end else begin
        setV = !en ? 32'd0 : (k == 1) ? (req & ~mPrev[k]) : req;
        clrV = (mValid[k] && ackV[k]) ? (32'd1 << mIdx[k]) : 32'd0;
        elig = mPend[k] & ~mask;
        if (!mValid[k]) begin
          if (elig != 0) begin
            mIdx[k] = pick(elig, mRr[k]);
            mValid[k] = 1'b1;
          end
        end else if (ackV[k]) begin
          mValid[k] = 1'b0;
`ifdef ENCODER32_ROUND_ROBIN_EN
          mRr[k] = mIdx[k] + 5'd1;
`endif
        end
        mPend[k] = (mPend[k] & ~clrV) | setV;
        mPrev[k] = req;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("model_valid", k, 32'(dVal[k]), 32'(mValid[k]));
        chk("model_pending", k, dPend[k], mPend[k]);
        if (mValid[k]) chk("model_index", k, 32'(dIdx[k]), 32'(mIdx[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int gcount [2];
  int seq [4];
  int ns;
  int waited;

  initial begin
    ackV[0] = 1'b0;
    ackV[1] = 1'b0;
    tick(); tick();
    reset = 1'b0;
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("t1_reset_valid", k, 32'(dVal[k]), 32'd0);
      chk("t1_reset_pending", k, dPend[k], 32'd0);
    end

    // T1
    req = 32'h1; tick(); req = '0;
    chk("t1_pend_set", 0, dPend[0], 32'h1);
    chk("t1_not_yet_valid", 0, 32'(dVal[0]), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("t1_valid", k, 32'(dVal[k]), 32'd1);
      chk("t1_index", k, 32'(dIdx[k]), 32'd0);
    end
    ackV[0] = 1'b1; ackV[1] = 1'b1; tick(); ackV[0] = 1'b0; ackV[1] = 1'b0;
    chk("t1_ack_valid", 0, 32'(dVal[0]), 32'd0);
    chk("t1_ack_pending", 0, dPend[0], 32'd0);

    // T2
    req = 32'h8000_0010; tick(); req = '0; tick();
    chk("t2_first", 0, 32'(dIdx[0]), 32'd4);
    ackV[0] = 1'b1; ackV[1] = 1'b1; tick(); ackV[0] = 1'b0; ackV[1] = 1'b0;
    chk("t2_bubble", 0, 32'(dVal[0]), 32'd0);
    tick();
    chk("t2_second", 0, 32'(dIdx[0]), 32'd31);
    chk("t2_second_valid", 1, 32'(dVal[1]), 32'd1);
    ackV[0] = 1'b1; ackV[1] = 1'b1; tick(); ackV[0] = 1'b0; ackV[1] = 1'b0;
    chk("t2_drained", 0, dPend[0], 32'd0);
    chk("t2_drained", 1, dPend[1], 32'd0);

    // T3
    mask = 32'h10; req = 32'h8000_0010; tick(); req = '0; tick();
    chk("t3_masked_first", 0, 32'(dIdx[0]), 32'd31);
    ackV[0] = 1'b1; ackV[1] = 1'b1; tick(); ackV[0] = 1'b0; ackV[1] = 1'b0;
    mask = '0; tick();
    chk("t3_unmasked", 0, 32'(dIdx[0]), 32'd4);
    chk("t3_unmasked_valid", 0, 32'(dVal[0]), 32'd1);
    ackV[0] = 1'b1; ackV[1] = 1'b1; tick(); ackV[0] = 1'b0; ackV[1] = 1'b0;
    chk("t3_drained", 0, dPend[0], 32'd0);

    // T4
    req = 32'h80; tick(); req = '0; tick();
    chk("t4_index7", 0, 32'(dIdx[0]), 32'd7);
    ackV[0] = 1'b1; ackV[1] = 1'b1; req = 32'h80; tick();
    ackV[0] = 1'b0; ackV[1] = 1'b0; req = '0;
    for (int k = 0; k < 2; k++) begin
      chk("t4_set_wins", k, 32'(dPend[k][7]), 32'd1);
      chk("t4_bubble", k, 32'(dVal[k]), 32'd0);
    end
    tick();
    chk("t4_regrant_valid", 0, 32'(dVal[0]), 32'd1);
    chk("t4_regrant_index", 0, 32'(dIdx[0]), 32'd7);
    ackV[0] = 1'b1; ackV[1] = 1'b1; tick(); ackV[0] = 1'b0; ackV[1] = 1'b0;

    // T5
    gcount[0] = 0; gcount[1] = 0;
    req = 32'h8;
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 2; k++) begin
        ackV[k] = dVal[k];
        if (dVal[k]) gcount[k]++;
      end
      tick();
    end
    req = '0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) ackV[k] = dVal[k];
      tick();
    end
    ackV[0] = 1'b0; ackV[1] = 1'b0;
    chk("t5_edge_one_grant", 1, 32'(gcount[1]), 32'd1);
    chk("t5_level_repeats", 0, 32'(gcount[0] >= 5), 32'd1);
    chk("t5_drained", 0, dPend[0], 32'd0);
    chk("t5_drained", 1, dPend[1], 32'd0);

    // T6
    req = 32'h11; ns = 0; waited = 0;
    while (ns < 4 && waited < 40) begin
      ackV[0] = dVal[0];
      ackV[1] = 1'b0;
      if (dVal[0]) begin
        seq[ns] = int'(dIdx[0]);
        ns++;
      end
      tick();
      waited++;
    end
    ackV[0] = 1'b0;
    chk("t6_grant_count", 0, 32'(ns), 32'd4);
`ifdef ENCODER32_ROUND_ROBIN_EN
    chk("t6_seq0", 0, 32'(seq[0]), 32'd0);
    chk("t6_seq1", 0, 32'(seq[1]), 32'd4);
    chk("t6_seq2", 0, 32'(seq[2]), 32'd0);
    chk("t6_seq3", 0, 32'(seq[3]), 32'd4);
`else
    chk("t6_seq0", 0, 32'(seq[0]), 32'd0);
    chk("t6_seq1", 0, 32'(seq[1]), 32'd0);
    chk("t6_seq2", 0, 32'(seq[2]), 32'd0);
    chk("t6_seq3", 0, 32'(seq[3]), 32'd0);
`endif
    waited = 0;
    while (!dVal[0] && waited < 10) begin
      tick();
      waited++;
    end
    chk("t6_in_hold", 0, 32'(dVal[0]), 32'd1);
    reset = 1'b1; tick();
    for (int k = 0; k < 2; k++) begin
      chk("t6_reset_valid", k, 32'(dVal[k]), 32'd0);
      chk("t6_reset_pending", k, dPend[k], 32'd0);
    end
    reset = 1'b0; req = '0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      req   = $urandom() & $urandom() & $urandom();
      mask  = ($urandom_range(0, 3) == 0) ? ($urandom() & $urandom()) : 32'd0;
      en    = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        ackV[k] = mValid[k] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    reset = 1'b0; req = '0; ackV[0] = 1'b0; ackV[1] = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
